// File: rtl/clause_mem_pkg.sv
// Shared types and clause-word layout for the BCP clause storage.
// The field offsets describe how literal/watch data is packed into one word.
package clause_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int CLAUSE_W = 18;

  // Two watched-literal indices followed by a clause size field.
  localparam int WATCH_W    = 7;
  localparam int WATCH0_LSB = 0;
  localparam int WATCH1_LSB = WATCH0_LSB + WATCH_W;
  localparam int SIZE_W     = 4;
  localparam int SIZE_LSB   = WATCH1_LSB + WATCH_W;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot combinational grant.
// The most recent winner drops to lowest priority.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  logic [LW-1:0] last;
  logic [LW-1:0] grant_idx;
  logic          found;

  // The first pass covers ports above last and the second pass wraps around.
  always_comb begin
    grant     = '0;
    grant_idx = last;
    found     = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i > int'(last))) begin
          grant[i]  = 1'b1;
          grant_idx = LW'(i);
          found     = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i <= int'(last))) begin
          grant[i]  = 1'b1;
          grant_idx = LW'(i);
          found     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= LW'(N - 1);
    end else if (found) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/clause_mem_arb.sv
// Clause storage shared by several BCP requestors.
// A clear sequence fills the array after reset; each response lasts one cycle.
module clause_mem_arb
  import clause_mem_pkg::*;
#(
  parameter int                DATA_W      = CLAUSE_W,
  parameter int                DEPTH       = 8,
  parameter int                ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int                N_PORTS     = 2,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_req,
  output logic                             busy,
  input  logic [N_PORTS-1:0]               req_valid,
  output logic [N_PORTS-1:0]               req_ready,
  input  logic [N_PORTS-1:0]               req_write,
  input  logic [N_PORTS-1:0][ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS-1:0][DATA_W-1:0]   req_wdata,
  output logic [N_PORTS-1:0]               rsp_valid,
  output logic [DATA_W-1:0]                rsp_data,
  output logic                             rsp_err
);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [N_PORTS-1:0] grant;
  logic               any_grant;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               in_range;

  rr_arbiter #(
    .N(N_PORTS)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  (req_valid),
    .en   (state == RUN),
    .grant(grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;
  assign in_range  = int'(sel_addr) < DEPTH;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i];
        sel_wdata = req_wdata[i];
      end
    end
  end

  // A clear request during CLEAR restarts the sweep from address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clear_req) begin
            clr_addr <= '0;
          end else if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state    <= RUN;
            busy     <= 1'b0;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        RUN: begin
          if (clear_req) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
          end
        end
        default: begin
          state    <= CLEAR;
          busy     <= 1'b1;
          clr_addr <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= CLEAR_VALUE;
    end else if (any_grant && sel_write && in_range) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // Out-of-range accesses still respond, but with zero data and the error flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= grant;
      rsp_err   <= any_grant && !in_range;
      if (!any_grant || !in_range) begin
        rsp_data <= '0;
      end else if (sel_write) begin
        rsp_data <= sel_wdata;
      end else begin
        rsp_data <= mem[sel_addr];
      end
    end
  end

endmodule
